// File: rtl/srl_pkg.sv
// srl_pkg: shared limits, tap index type and counter-width helper for the SRL FIFO
package srl_pkg;
    localparam int SRL_MAX_DEPTH = 64;
    typedef logic [$clog2(SRL_MAX_DEPTH)-1:0] tap_t;
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 2);
    endfunction
endpackage

// File: rtl/srl_fifo_if.sv
// srl_fifo_if: write/read handshake bundle; level and almost_full exist only with SRL_FIFO_STATUS_EN
interface srl_fifo_if #(
    parameter int WIDTH = 18
`ifdef SRL_FIFO_STATUS_EN
    , parameter int DEPTH = 32
`endif
);
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
`ifdef SRL_FIFO_STATUS_EN
    logic [srl_pkg::cnt_width(DEPTH)-1:0] level;
    logic                                 almost_full;
    modport slave  (input s_valid, s_data, m_ready, output s_ready, m_valid, m_data, level, almost_full);
    modport master (output s_valid, s_data, m_ready, input s_ready, m_valid, m_data, level, almost_full);
`else
    modport slave  (input s_valid, s_data, m_ready, output s_ready, m_valid, m_data);
    modport master (output s_valid, s_data, m_ready, input s_ready, m_valid, m_data);
`endif
endinterface

// File: rtl/srl_tap_line.sv
// srl_tap_line: shift register with a combinational variable read tap; no reset so it maps to LUT-RAM
module srl_tap_line
    import srl_pkg::*;
#(
    parameter int WIDTH = 18,
    parameter int DEPTH = 32
) (
    input  logic             clk,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    input  tap_t             addr,
    output logic [WIDTH-1:0] dout
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] r_srl [DEPTH];
    always_ff @(posedge clk) begin
        if (en) begin
            r_srl[0] <= din;
            for (int i = 1; i < DEPTH; i++) r_srl[i] <= r_srl[i-1];
        end
    end
    assign dout = r_srl[addr[AW-1:0]];
    // shallow lines only decode the low tap bits
    if (AW < $bits(tap_t)) begin : g_hi
        logic w_unused_hi;
        assign w_unused_hi = |addr[$bits(tap_t)-1:AW];
    end
endmodule

// File: rtl/srl_fifo.sv
// srl_fifo: SRL-backed FIFO with a registered valid/ready output stage
// SRL_FIFO_STATUS_EN adds the level and registered almost_full outputs
module srl_fifo
    import srl_pkg::*;
#(
    parameter int WIDTH       = 18,
    parameter int DEPTH       = 32,
    parameter int ALMOST_FULL = DEPTH - 2
) (
    input logic       clk,
    input logic       rst_n,
    srl_fifo_if.slave bus
);
    localparam int CW = cnt_width(DEPTH);
    if (DEPTH < 2 || DEPTH > SRL_MAX_DEPTH || ALMOST_FULL < 0 || ALMOST_FULL > DEPTH + 1) begin : g_bad_cfg
        $error("srl_fifo: unsupported DEPTH or ALMOST_FULL");
    end
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             r_m_valid;
    logic             w_m_valid_nxt;
    logic [WIDTH-1:0] r_m_data;
    logic [WIDTH-1:0] w_tap_data;
    logic             w_s_ready;
    logic             w_push;
    logic             w_load;
    tap_t             w_tap;
    // s_ready comes from the counter alone, so a full SRL refuses even when a pop frees space
    assign w_s_ready     = (r_cnt != CW'(DEPTH));
    assign w_push        = bus.s_valid & w_s_ready;
    assign w_load        = (r_cnt != '0) & (!r_m_valid | bus.m_ready);
    assign w_tap         = tap_t'(r_cnt - 1'b1);
    assign w_cnt_nxt     = r_cnt + CW'(w_push) - CW'(w_load);
    assign w_m_valid_nxt = w_load | (r_m_valid & !bus.m_ready);
    srl_tap_line #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_tap (
        .clk (clk),
        .en  (w_push),
        .din (bus.s_data),
        .addr(w_tap),
        .dout(w_tap_data)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_m_valid <= w_m_valid_nxt;
            if (w_load) r_m_data <= w_tap_data;
        end
    end
    assign bus.s_ready = w_s_ready;
    assign bus.m_valid = r_m_valid;
    assign bus.m_data  = r_m_data;
`ifdef SRL_FIFO_STATUS_EN
    logic [CW-1:0] w_level_nxt;
    logic          r_af;
    assign w_level_nxt = w_cnt_nxt + CW'(w_m_valid_nxt);
    always_ff @(posedge clk) begin
        if (!rst_n) r_af <= 1'b0;
        else        r_af <= (w_level_nxt >= CW'(ALMOST_FULL));
    end
    assign bus.level       = r_cnt + CW'(r_m_valid);
    assign bus.almost_full = r_af;
`endif
endmodule

// File: doc/srl_fifo.md
# srl_fifo

Synchronous FIFO built on an addressable shift-register (SRL) store: the consumer-side counterpart to the fixed-length SRL delay lines in the datapath. Writes always shift into tap 0. Reads are taken from a variable tap selected by the current occupancy, then registered into a valid/ready output stage. It sits between an SRL-delayed producer and a back-pressuring consumer, sized for LUT-RAM inference with no storage reset.

## Interface
- `WIDTH`, default 18: data width in bits.
- `DEPTH`, default 32: SRL storage entries, ≥2. Total capacity is DEPTH+1, including the output register.
- `ALMOST_FULL`, default DEPTH-2: level threshold for `almost_full`. Used only when `SRL_FIFO_STATUS_EN` is defined.
- `clk` in 1: single clock, all logic on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `s_valid` in 1: write request.
- `s_ready` out 1: write accept.
- `s_data` in WIDTH: write data.
- `m_valid` out 1: output data valid.
- `m_ready` in 1: consumer accept.
- `m_data` out WIDTH: registered output data.
- `level` out $clog2(DEPTH+2): occupancy, counting SRL entries plus the output register. Present only with `SRL_FIFO_STATUS_EN`.
- `almost_full` out 1: registered flag, high when `level` ≥ ALMOST_FULL. Present only with `SRL_FIFO_STATUS_EN`.

## Operation
- **Internal state**
  - `srl_cnt`: 0..DEPTH, entries held in the SRL.
  - `m_valid`: output register occupied.
  - Oldest SRL entry is at tap `srl_cnt-1`.
- **Push:** `push = s_valid & s_ready`.
  - `s_ready = (srl_cnt != DEPTH)`.
  - `s_ready` is driven from registered state only, with no combinational path from `m_ready`.
  - A full SRL refuses a write even in a cycle where a pop frees space.
- **Load:** `load = (srl_cnt != 0) & (!m_valid | m_ready)`.
  - `m_data` takes `srl[srl_cnt-1]`, read before this edge's shift.
  - `m_valid` is set to 1.
- **Drain:** `m_valid & m_ready & !load` clears `m_valid`. `m_data` holds its last value.
- **Counter update**
  - push & !load: `srl_cnt+1`.
  - load & !push: `srl_cnt-1`.
  - both or neither: unchanged.
- **No bypass:** data always passes through the SRL, even when the FIFO is empty.
- **Ordering:** strict FIFO order, no reordering and no duplication.
- **Ignored requests:** `s_valid` with `s_ready` low is ignored; the producer must hold `s_data`. No overflow or underflow is possible through the ports.
- **Storage reset:** SRL storage is never reset; stale contents are unreachable because of `srl_cnt`.
- **Reset** (`rst_n` low at a rising edge)
  - `srl_cnt` = 0, `m_valid` = 0, `m_data` = 0.
  - `level` = 0, `almost_full` = 0.
  - `s_ready` = 1 in the cycle after reset.
  - Reset mid-operation discards all contents. A push coincident with reset is dropped.

## Timing
- Push-to-output latency: data pushed at edge N is visible with `m_valid`=1 after edge N+1 (2 cycles).
- Throughput: one word per cycle in steady state with `m_ready` held high.
- `m_valid`/`m_data` hold stable while `m_valid & !m_ready`.
- `level` and `almost_full` update on the same edge as the state they reflect.
- No combinational path from any input to any output except `s_ready`, which depends only on flops.

## Configuration
- Macro: `SRL_FIFO_STATUS_EN`.
- **Defined:**
  - `level` and `almost_full` ports exist.
  - `level` = `srl_cnt + m_valid`.
  - `almost_full` is registered.
- **Undefined:** both ports and their logic are absent; all other behaviour is identical.

## Structure
- **Package `srl_pkg`**
  - Function `cnt_width(depth)` returning `$clog2(depth+2)`.
  - Shared typedef for SRL tap index.
  - Constant `SRL_MAX_DEPTH` = 64. Elaboration fails if DEPTH exceeds it or is below 2.
- **Sub-module `srl_tap_line`**
  - Parameters WIDTH, DEPTH.
  - Ports: `clk`, `en`, `din`, `addr`, `dout`.
  - Shift on `en`; `dout` = `srl[addr]` combinationally.
  - No reset.
- **Top level:** `srl_fifo` holds the counter, handshake and output register.

## Test plan
- Reset, then push 0x00001 at edge 1 with `m_ready`=1.
  - `m_valid`=1 and `m_data`=0x00001 after edge 2.
  - Then `m_valid`=0 after edge 3.
- Fill with `m_ready`=0: push 0..33.
  - 33 words are accepted (32 SRL + 1 output).
  - `s_ready`=0 after the 33rd; the 34th push is ignored.
  - Draining yields 0..32 in order.
- Full with `m_ready`=1 and `s_valid`=1 the same cycle.
  - Pop occurs, push is refused that cycle.
  - `s_ready`=1 the next cycle.
- Continuous stream with random `m_ready` (50%), 1000 words.
  - Output equals input sequence.
  - `m_data` is stable whenever `m_valid & !m_ready`.
- Load 10 words, assert `rst_n`=0 for one edge.
  - `m_valid`=0, `s_ready`=1, `m_data`=0 after the edge.
  - A subsequent single push emerges alone after 2 cycles.
- `SRL_FIFO_STATUS_EN` with ALMOST_FULL=30:
  - After 30 pushes with no pops, `level`=30 and `almost_full`=1.
  - After one pop, `level`=29 and `almost_full`=0.
